// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SPI memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W  = 25;
  localparam int unsigned MEM_DATA_W  = 32;
  localparam int unsigned NUM_BYTES_W = 3;
  localparam int unsigned NUM_PORTS   = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory bus arbiter.
// MEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie; otherwise round-robin on last_grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_c_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // One-hot winner; bit N set means port N wins.
  always_comb begin
    grant_c_o = 2'b00;
    if (req0_i && req1_i) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_c_o = 2'b01;
`else
      grant_c_o = (last_grant_i == PORT_CPU) ? 2'b10 : 2'b01;
`endif
    end else if (req0_i) begin
      grant_c_o = 2'b01;
    end else if (req1_i) begin
      grant_c_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of the SPI memory controller; atomic level-handshake transactions.
// Build option MEM_ARB_FIXED_PRIO_EN (in mem_arb_pick) selects fixed port-0 priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_start,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic                   req0_write,
  input  logic [DATA_W-1:0]      req0_wdata,
  input  logic [NUM_BYTES_W-1:0] req0_num_bytes,
  output logic                   req0_done,
  input  logic                   req1_start,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic                   req1_write,
  input  logic [DATA_W-1:0]      req1_wdata,
  input  logic [NUM_BYTES_W-1:0] req1_num_bytes,
  output logic                   req1_done,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             grant,
  output logic                   mem_start,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [NUM_BYTES_W-1:0] mem_num_bytes,
  input  logic                   mem_done,
  input  logic [DATA_W-1:0]      mem_rdata
);

  arb_state_e             state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   mem_start_q, mem_start_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   mem_write_q, mem_write_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [NUM_BYTES_W-1:0] mem_num_bytes_q, mem_num_bytes_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [1:0]             pick_c;
  logic                   owner_start_c;

  mem_arb_pick u_pick (
    .req0_i       (req0_start),
    .req1_i       (req1_start),
    .last_grant_i (last_grant_q),
    .grant_c_o    (pick_c)
  );

  assign owner_start_c = grant_q[1] ? req1_start : req0_start;

  // State and datapath registers; last_grant resets to AUX so CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      grant_q         <= 2'b00;
      last_grant_q    <= PORT_AUX;
      mem_start_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_write_q     <= 1'b0;
      mem_wdata_q     <= '0;
      mem_num_bytes_q <= '0;
      done0_q         <= 1'b0;
      done1_q         <= 1'b0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      mem_start_q     <= mem_start_d;
      mem_addr_q      <= mem_addr_d;
      mem_write_q     <= mem_write_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_num_bytes_q <= mem_num_bytes_d;
      done0_q         <= done0_d;
      done1_q         <= done1_d;
      rdata_q         <= rdata_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    mem_start_d     = mem_start_q;
    mem_addr_d      = mem_addr_q;
    mem_write_d     = mem_write_q;
    mem_wdata_d     = mem_wdata_q;
    mem_num_bytes_d = mem_num_bytes_q;
    done0_d         = done0_q;
    done1_d         = done1_q;
    rdata_d         = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_c != 2'b00) begin
          grant_d     = pick_c;
          mem_start_d = 1'b1;
          state_d     = ST_BUSY;
          if (pick_c[1]) begin
            mem_addr_d      = req1_addr;
            mem_write_d     = req1_write;
            mem_wdata_d     = req1_wdata;
            mem_num_bytes_d = req1_num_bytes;
          end else begin
            mem_addr_d      = req0_addr;
            mem_write_d     = req0_write;
            mem_wdata_d     = req0_wdata;
            mem_num_bytes_d = req0_num_bytes;
          end
        end
      end

      ST_BUSY: begin
        if (mem_done) begin
          rdata_d     = mem_rdata;
          mem_start_d = 1'b0;
          done0_d     = grant_q[0];
          done1_d     = grant_q[1];
          state_d     = ST_DONE;
        end
      end

      // Owner releases start; a still-high mem_done must drop before re-arbitrating.
      ST_DONE: begin
        if (!owner_start_c) begin
          done0_d      = 1'b0;
          done1_d      = 1'b0;
          last_grant_d = grant_q[1];
          if (!mem_done) begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!mem_done) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req0_done     = done0_q;
  assign req1_done     = done1_q;
  assign rdata         = rdata_q;
  assign grant         = grant_q;
  assign mem_start     = mem_start_q;
  assign mem_addr      = mem_addr_q;
  assign mem_write     = mem_write_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_num_bytes = mem_num_bytes_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a level-handshake memory controller model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = MEM_ADDR_W;
  localparam int unsigned DW = MEM_DATA_W;

  logic          clk;
  logic          rst_n;
  logic          req0_start, req1_start;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_write, req1_write;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic [2:0]    req0_num_bytes, req1_num_bytes;
  logic          req0_done, req1_done;
  logic [DW-1:0] rdata;
  logic [1:0]    grant;
  logic          mem_start;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_num_bytes;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  int            n_vec;
  int            n_miss;
  int            mdl_lat;
  int            mdl_hold;
  logic [DW-1:0] mdl_rdata;
  int            m_cnt;
  int            m_hcnt;

  mem_bus_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_start     (req0_start),
    .req0_addr      (req0_addr),
    .req0_write     (req0_write),
    .req0_wdata     (req0_wdata),
    .req0_num_bytes (req0_num_bytes),
    .req0_done      (req0_done),
    .req1_start     (req1_start),
    .req1_addr      (req1_addr),
    .req1_write     (req1_write),
    .req1_wdata     (req1_wdata),
    .req1_num_bytes (req1_num_bytes),
    .req1_done      (req1_done),
    .rdata          (rdata),
    .grant          (grant),
    .mem_start      (mem_start),
    .mem_addr       (mem_addr),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_num_bytes  (mem_num_bytes),
    .mem_done       (mem_done),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: done mdl_lat cycles after start, released mdl_hold cycles after start drops.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      m_cnt     <= 0;
      m_hcnt    <= 0;
    end else if (!mem_done) begin
      m_hcnt <= 0;
      if (mem_start) begin
        if (m_cnt >= mdl_lat - 1) begin
          mem_done  <= 1'b1;
          mem_rdata <= mdl_rdata;
          m_cnt     <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end else if (!mem_start) begin
      if (m_hcnt >= mdl_hold) mem_done <= 1'b0;
      else                    m_hcnt   <= m_hcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_done(input logic port, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (port ? req1_done : req0_done) break;
    end
    chk(tag, 64'(port ? req1_done : req0_done), 64'(1'b1));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant == 2'b00 && !mem_done) break;
    end
    chk(tag, 64'(grant), 64'(2'b00));
  endtask

  task automatic drive(input logic port, input logic start, input logic [AW-1:0] addr,
                       input logic write, input logic [DW-1:0] wdata, input logic [2:0] nb);
    if (port) begin
      req1_start = start; req1_addr = addr; req1_write = write;
      req1_wdata = wdata; req1_num_bytes = nb;
    end else begin
      req0_start = start; req0_addr = addr; req0_write = write;
      req0_wdata = wdata; req0_num_bytes = nb;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    exp_oh;
    logic          exp_port;
    logic [AW-1:0] exp_addr;
    int            n_drain;
    int            pulses;

    n_vec = 0; n_miss = 0;
    mdl_lat = 20; mdl_hold = 0; mdl_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 3'd0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 3'd0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_mem_start", 64'(mem_start), 64'(1'b0));
    chk("rst_grant",     64'(grant),     64'(2'b00));
    chk("rst_done",      64'({req1_done, req0_done}), 64'(2'b00));
    chk("rst_rdata",     64'(rdata),     64'(32'h0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(25'h0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single CPU load
    drive(1'b0, 1'b1, 25'h000100, 1'b0, '0, 3'd4);
    chk("t1_pre_start", 64'(mem_start), 64'(1'b0));
    @(negedge clk);
    chk("t1_mem_start", 64'(mem_start),     64'(1'b1));
    chk("t1_grant",     64'(grant),         64'(2'b01));
    chk("t1_mem_addr",  64'(mem_addr),      64'(25'h000100));
    chk("t1_mem_nb",    64'(mem_num_bytes), 64'(3'd4));
    chk("t1_mem_write", 64'(mem_write),     64'(1'b0));
    wait_done(1'b0, "t1_done");
    chk("t1_rdata",     64'(rdata),     64'(32'hDEAD_BEEF));
    chk("t1_req1_done", 64'(req1_done), 64'(1'b0));
    req0_start = 1'b0;
    @(negedge clk);
    chk("t1_done_clr", 64'(req0_done), 64'(1'b0));
    wait_idle("t1_idle");

    // Simultaneous requests from reset: alternation (or port 0 under fixed priority)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_lat = 4;
    drive(1'b0, 1'b1, 25'h0000010, 1'b0, '0, 3'd4);
    drive(1'b1, 1'b1, 25'h1000010, 1'b0, '0, 3'd4);
    for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_port = 1'b0;
`else
      exp_port = (r % 2 == 1);
`endif
      exp_oh   = exp_port ? 2'b10 : 2'b01;
      exp_addr = exp_port ? 25'h1000010 : 25'h0000010;
      mdl_rdata = 32'hA000_0000 + 32'(r);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (req0_done || req1_done) break;
      end
      chk("t2_grant",    64'(grant),                  64'(exp_oh));
      chk("t2_done_oh",  64'({req1_done, req0_done}), 64'(exp_oh));
      chk("t2_mem_addr", 64'(mem_addr),               64'(exp_addr));
      chk("t2_rdata",    64'(rdata),                  64'(32'hA000_0000 + 32'(r)));
      if (exp_port) req1_start = 1'b0; else req0_start = 1'b0;
      @(negedge clk);
      if (exp_port) req1_start = 1'b1; else req0_start = 1'b1;
    end
    req0_start = 1'b0;
    req1_start = 1'b0;
    wait_idle("t2_idle");

    // Store pass-through, latched fields stable while requester inputs toggle
    mdl_lat = 10;
    drive(1'b1, 1'b1, 25'h0000200, 1'b1, 32'h1234_5678, 3'd2);
    @(negedge clk);
    chk("t3_grant",     64'(grant),         64'(2'b10));
    chk("t3_mem_write", 64'(mem_write),     64'(1'b1));
    chk("t3_mem_wdata", 64'(mem_wdata),     64'(32'h1234_5678));
    chk("t3_mem_nb",    64'(mem_num_bytes), 64'(3'd2));
    for (int i = 0; i < 3; i++) begin
      req1_wdata = ~req1_wdata;
      req1_write = ~req1_write;
      req1_num_bytes = 3'(i + 3);
      req1_addr = req1_addr ^ 25'h1FF_FFFF;
      @(negedge clk);
      chk("t3_hold_wdata", 64'(mem_wdata),     64'(32'h1234_5678));
      chk("t3_hold_write", 64'(mem_write),     64'(1'b1));
      chk("t3_hold_nb",    64'(mem_num_bytes), 64'(3'd2));
      chk("t3_hold_addr",  64'(mem_addr),      64'(25'h0000200));
    end
    wait_done(1'b1, "t3_done");
    req1_start = 1'b0;
    wait_idle("t3_idle");

    // Late mem_done release: pending port 1 waits for the drain
    mdl_lat = 4; mdl_hold = 3;
    drive(1'b0, 1'b1, 25'h0000300, 1'b0, '0, 3'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 25'h0000400, 1'b0, '0, 3'd1);
    wait_done(1'b0, "t4_done0");
    req0_start = 1'b0;
    n_drain = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_done) break;
      chk("t4_drain_grant", 64'(grant), 64'(2'b01));
      n_drain++;
    end
    chk("t4_drain_len",  64'(n_drain), 64'(3));
    chk("t4_last_drain", 64'(grant),   64'(2'b01));
    mdl_hold = 0;
    @(negedge clk);
    chk("t4_idle_gap", 64'(grant), 64'(2'b00));
    @(negedge clk);
    chk("t4_grant1",    64'(grant),    64'(2'b10));
    chk("t4_mem_addr1", 64'(mem_addr), 64'(25'h0000400));
    wait_done(1'b1, "t4_done1");
    req1_start = 1'b0;
    wait_idle("t4_idle");

    // Abort: port 0 drops start 2 cycles into BUSY, queued port 1 then served
    mdl_lat = 8;
    drive(1'b0, 1'b1, 25'h0000500, 1'b0, '0, 3'd4);
    @(negedge clk);
    chk("t5_grant0", 64'(grant),     64'(2'b01));
    chk("t5_busy",   64'(mem_start), 64'(1'b1));
    drive(1'b1, 1'b1, 25'h0000600, 1'b0, '0, 3'd4);
    repeat (2) @(negedge clk);
    req0_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req0_done) pulses++;
      if (grant == 2'b10) break;
    end
    chk("t5_done_pulse", 64'(pulses),   64'(1));
    chk("t5_grant1",     64'(grant),    64'(2'b10));
    chk("t5_mem_addr1",  64'(mem_addr), 64'(25'h0000600));
    wait_done(1'b1, "t5_done1");
    req1_start = 1'b0;
    wait_idle("t5_idle");

    // Reset mid-BUSY after a port 0 transaction: tie afterwards goes to port 0
    mdl_lat = 4;
    drive(1'b0, 1'b1, 25'h0000700, 1'b0, '0, 3'd4);
    wait_done(1'b0, "t6_pre_done");
    req0_start = 1'b0;
    wait_idle("t6_pre_idle");
    mdl_lat = 20;
    drive(1'b1, 1'b1, 25'h0000800, 1'b0, '0, 3'd4);
    repeat (3) @(negedge clk);
    chk("t6_busy", 64'(mem_start), 64'(1'b1));
    rst_n = 1'b0;
    req1_start = 1'b0;
    @(negedge clk);
    chk("t6_rst_mem_start", 64'(mem_start), 64'(1'b0));
    chk("t6_rst_grant",     64'(grant),     64'(2'b00));
    chk("t6_rst_done",      64'({req1_done, req0_done}), 64'(2'b00));
    chk("t6_rst_rdata",     64'(rdata),     64'(32'h0));
    rst_n = 1'b1;
    mdl_lat = 4;
    drive(1'b0, 1'b1, 25'h0000900, 1'b0, '0, 3'd4);
    drive(1'b1, 1'b1, 25'h0000A00, 1'b0, '0, 3'd4);
    @(negedge clk);
    chk("t6_tie_grant",    64'(grant),    64'(2'b01));
    chk("t6_tie_mem_addr", 64'(mem_addr), 64'(25'h0000900));
    wait_done(1'b0, "t6_done0");
    req0_start = 1'b0;
    wait_done(1'b1, "t6_done1");
    req1_start = 1'b0;
    wait_idle("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
